// File: rtl/sync_fifo_buffer_pkg.sv
// rtl/sync_fifo_buffer_pkg.sv - shared types and helpers for the synchronous FIFO
package sync_fifo_buffer_pkg;

  // Operation accepted in a cycle, encoded as {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic wr_ok, input logic rd_ok);
    return fifo_op_e'({wr_ok, rd_ok});
  endfunction

endpackage

// File: rtl/sync_fifo_buffer_if.sv
// rtl/sync_fifo_buffer_if.sv - FIFO bus interface with device and host views
interface sync_fifo_interface #(
  parameter int DATA_WIDTH = 32
) (
  input logic clk_i
);

  logic                  rst_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  full_o;
  logic                  empty_o;

  modport DEVICE (
    input  clk_i,
    input  rst_i,
    input  wr_en_i,
    input  wr_data_i,
    input  rd_en_i,
    output rd_data_o,
    output full_o,
    output empty_o
  );

  modport HOST (
    input  clk_i,
    output rst_i,
    output wr_en_i,
    output wr_data_i,
    output rd_en_i,
    input  rd_data_o,
    input  full_o,
    input  empty_o
  );

endinterface

// File: rtl/sync_fifo_buffer_ram.sv
// rtl/sync_fifo_buffer_ram.sv - FIFO storage: one synchronous write port, one asynchronous read port
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read lets first-word-fall-through show the head word directly.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_buffer.sv
// rtl/sync_fifo_buffer.sv - synchronous FIFO: wrap-bit pointers, flags and read-data path
module sync_fifo_buffer
  import sync_fifo_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int FWFT       = 0
) (
  sync_fifo_interface.DEVICE bus
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  rd_ok;
  logic                  wr_ok;
  fifo_op_e              op;
  logic [DATA_WIDTH-1:0] head_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

  // A write into a full FIFO is still taken when a read frees the slot this cycle.
  assign rd_ok = bus.rd_en_i && !empty;
  assign wr_ok = bus.wr_en_i && (!full || rd_ok);
  assign op    = decode_op(wr_ok, rd_ok);

  always_ff @(posedge bus.clk_i) begin
    if (bus.rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case (op)
        OP_WRITE: wr_ptr <= wr_ptr + PTR_ONE;
        OP_READ:  rd_ptr <= rd_ptr + PTR_ONE;
        OP_BOTH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (IDX_W)
  ) u_ram (
    .clk     (bus.clk_i),
    .wr_en   (wr_ok && !bus.rst_i),
    .wr_addr (wr_ptr[IDX_W-1:0]),
    .wr_data (bus.wr_data_i),
    .rd_addr (rd_ptr[IDX_W-1:0]),
    .rd_data (head_data)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data_o = empty ? '0 : head_data;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge bus.clk_i) begin
        if (bus.rst_i) begin
          rd_data_q <= '0;
        end else if (rd_ok) begin
          rd_data_q <= head_data;
        end
      end

      assign bus.rd_data_o = rd_data_q;
    end
  endgenerate

  assign bus.full_o  = full;
  assign bus.empty_o = empty;

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// tb/tb_sync_fifo_buffer.sv - self-checking bench for standard and FWFT FIFO variants
module tb_sync_fifo_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_interface #(.DATA_WIDTH(DW)) if0 (.clk_i(clk));
  sync_fifo_interface #(.DATA_WIDTH(DW)) if1 (.clk_i(clk));

  sync_fifo_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) dut0 (.bus(if0));
  sync_fifo_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) dut1 (.bus(if1));

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd0 = '0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive both FIFOs identically, advance the queue model, compare.
  task automatic step(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] d);
    bit was_full;
    bit was_empty;
    bit rd_take;
    bit wr_take;
    logic [DW-1:0] exp_rd1;
    if0.rst_i = rst; if0.wr_en_i = wr; if0.rd_en_i = rd; if0.wr_data_i = d;
    if1.rst_i = rst; if1.wr_en_i = wr; if1.rd_en_i = rd; if1.wr_data_i = d;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      exp_rd0 = '0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      rd_take   = rd && !was_empty;
      wr_take   = wr && (!was_full || rd_take);
      if (rd_take) exp_rd0 = q.pop_front();
      if (wr_take) q.push_back(d);
    end
    exp_rd1 = (q.size() != 0) ? q[0] : '0;
    check("empty0", DW'(if0.empty_o), DW'(q.size() == 0));
    check("full0",  DW'(if0.full_o),  DW'(q.size() == DEPTH));
    check("rd0",    if0.rd_data_o,    exp_rd0);
    check("empty1", DW'(if1.empty_o), DW'(q.size() == 0));
    check("full1",  DW'(if1.full_o),  DW'(q.size() == DEPTH));
    check("rd1",    if1.rd_data_o,    exp_rd1);
  endtask

  initial begin
    logic [DW-1:0] head;

    if0.rst_i = 1'b1; if0.wr_en_i = 1'b0; if0.rd_en_i = 1'b0; if0.wr_data_i = '0;
    if1.rst_i = 1'b1; if1.wr_en_i = 1'b0; if1.rd_en_i = 1'b0; if1.wr_data_i = '0;

    // Reset with both requests asserted, then idle.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("idle_empty", DW'(if0.empty_o), 32'd1);
    check("idle_full",  DW'(if0.full_o),  32'd0);
    check("idle_rd",    if0.rd_data_o,    32'd0);

    // Fill with 0..31, then an ignored write while full.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'(i));
    end
    check("fill_full", DW'(if0.full_o), 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0000_DEAD);
    check("ovf_full", DW'(if0.full_o), 32'd1);

    // Drain in order, then an extra read on empty.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check("drain_order", if0.rd_data_o, DW'(i));
    end
    check("drain_empty", DW'(if0.empty_o), 32'd1);
    step(1'b0, 1'b0, 1'b1, '0);
    check("underflow_hold", if0.rd_data_o, 32'd31);

    // Bursts of 20 in / 20 out force pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, $urandom);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, '0);
    end

    // Simultaneous read and write while full.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, $urandom);
    head = q[0];
    step(1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5);
    check("rw_full_stays", DW'(if0.full_o), 32'd1);
    check("rw_full_head",  if0.rd_data_o,   head);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, '0);
    check("rw_full_last", if0.rd_data_o, 32'hA5A5_A5A5);

    // Simultaneous read and write on empty performs only the write.
    step(1'b0, 1'b1, 1'b1, 32'h0BAD_F00D);
    check("rw_empty_notempty", DW'(if0.empty_o), 32'd0);
    check("rw_empty_hold",     if0.rd_data_o,    32'hA5A5_A5A5);

    // FWFT: data falls through one cycle after the write; reset mid-stream.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 32'h1234_5678);
    check("fwft_fall_through", if1.rd_data_o, 32'h1234_5678);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b1, 32'h5555_AAAA);
    check("fwft_rst_empty", DW'(if1.empty_o), 32'd1);
    check("fwft_rst_data",  if1.rd_data_o,    32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), $urandom);
    end
    for (int i = 0; i < 800; i++) begin
      step(1'b0, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
